pixel_dispatcher: RTL and testbench
===================================

PIXEL_DISPATCHER -- requirements
Module: pixel_dispatcher

Interface
REQ-001 Parameter NUM_ENGINES, default 4: number of engines served (2..32).
REQ-002 Parameter DATA_WIDTH, default 10: pixel coordinate width.
REQ-003 Parameter X_PIXELS, default 640: pixels per line.
REQ-004 Parameter Y_PIXELS, default 480: lines per frame.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 start  input  1  begin frame; sampled only in IDLE.
REQ-008 engine_idle  input  NUM_ENGINES  engine i can accept a new pixel.
REQ-009 engine_full  input  NUM_ENGINES  engine i's output queue full; do not dispatch.
REQ-010 grant  output  NUM_ENGINES  registered one-hot load strobe to engine i.
REQ-011 load  output  1  OR of grant; xpixel/ypixel valid when 1.
REQ-012 xpixel  output  DATA_WIDTH  dispatched pixel x coordinate.
REQ-013 ypixel  output  DATA_WIDTH  dispatched pixel y coordinate.
REQ-014 busy  output  1  high in DISPATCH and DRAIN.
REQ-015 frame_done  output  1  one-cycle pulse when frame fully computed.
REQ-016 stall_count  output  32  stall-cycle counter (present only with macro, REQ-037).

Function
REQ-017 FSM states SHALL be IDLE, DISPATCH, DRAIN, DONE.
REQ-018 IDLE: start=1 -> DISPATCH next cycle; scan x=0, y=0, round-robin pointer=0.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 eligible[i] SHALL equal engine_idle[i] & ~engine_full[i] & ~grant[i] (engine granted last cycle excluded for one cycle).
REQ-021 DISPATCH: if any eligible, grant SHALL select the first eligible index searching upward from pointer, wrapping modulo NUM_ENGINES.
REQ-022 After a grant to index k, pointer SHALL become (k+1) mod NUM_ENGINES; with no grant pointer holds.
REQ-023 At most one grant per cycle; grant, load, xpixel, ypixel SHALL be registered, appearing one cycle after the eligibility decision.
REQ-024 xpixel/ypixel SHALL carry the current scan coordinate on the grant cycle and hold their last value otherwise.
REQ-025 Scan order raster: x increments per grant; at x=X_PIXELS-1, x wraps to 0 and y increments.
REQ-026 Grant of (X_PIXELS-1, Y_PIXELS-1) SHALL move FSM to DRAIN; no further grants in the frame.
REQ-027 No eligible engine in DISPATCH: load=0, scan and pointer hold (stall cycle).
REQ-028 DRAIN: when grant=0 and engine_idle all ones -> DONE.
REQ-029 DONE: frame_done=1 for exactly one cycle, then IDLE.
REQ-030 Every frame SHALL issue exactly X_PIXELS*Y_PIXELS grants, each coordinate once.

Reset
REQ-031 reset=0 SHALL asynchronously force state IDLE regardless of current state, including mid-frame.
REQ-032 Reset values: grant=0, load=0, xpixel=0, ypixel=0, busy=0, frame_done=0, pointer=0, scan x=y=0, stall_count=0.
REQ-033 A frame interrupted by reset SHALL NOT resume; a new start restarts at (0,0).

Configuration
REQ-034 Macro DISPATCH_STALL_COUNT_EN controls the stall counter.
REQ-035 Defined: 32-bit counter increments on each DISPATCH stall cycle, saturates at all ones, clears on reset and on start acceptance.
REQ-036 Not defined: counter logic absent; dispatch behaviour identical.
REQ-037 Port stall_count SHALL exist only when DISPATCH_STALL_COUNT_EN is defined.

Verification
REQ-038 All idle, none full, X_PIXELS=4, Y_PIXELS=2, start pulse -> 8 grants, order engines 0,1,2,3,0,...(with one-cycle exclusion respected), coords (0,0)..(3,1) raster, frame_done once.
REQ-039 engine_full=4'b0010 throughout -> engine 1 never granted; grants rotate 0,2,3.
REQ-040 All engine_idle=0 for 5 DISPATCH cycles -> no load, scan holds; with macro, stall_count=5.
REQ-041 Last pixel granted, engine 2 idle=0 for 10 cycles -> stays DRAIN, frame_done 1 cycle after engine 2 returns idle.
REQ-042 reset=0 mid-frame at pixel (2,1) -> outputs at reset values immediately; next start begins at (0,0), pointer 0.
REQ-043 start asserted during DISPATCH -> ignored; grant count still X_PIXELS*Y_PIXELS.

Source files
------------

// File: rtl/pixel_dispatcher.sv
// Raster-scans one frame of X_PIXELS x Y_PIXELS and hands each pixel to an engine in round-robin order.
// Defining DISPATCH_STALL_COUNT_EN adds the stall_count port and its saturating stall-cycle counter.
module pixel_dispatcher #(
  parameter int NUM_ENGINES = 4,
  parameter int DATA_WIDTH  = 10,
  parameter int X_PIXELS    = 640,
  parameter int Y_PIXELS    = 480
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_ENGINES-1:0] engine_idle,
  input  logic [NUM_ENGINES-1:0] engine_full,
  output logic [NUM_ENGINES-1:0] grant,
  output logic                   load,
  output logic [DATA_WIDTH-1:0]  xpixel,
  output logic [DATA_WIDTH-1:0]  ypixel,
  output logic                   busy,
  output logic                   frame_done
`ifdef DISPATCH_STALL_COUNT_EN
  ,
  output logic [31:0]            stall_count
`endif
);

  localparam int PW = $clog2(NUM_ENGINES);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  state_t                   state, state_next;
  logic [PW-1:0]            ptr, ptr_next;
  logic [DATA_WIDTH-1:0]    scan_x, scan_y, scan_x_next, scan_y_next;
  logic [NUM_ENGINES-1:0]   eligible, grant_next;
  logic [2*NUM_ENGINES-1:0] rotated;
  logic [PW-1:0]            sel;
  logic                     found;
  logic                     last_x, last_pixel;
  int                       pos;

  // An engine granted last cycle sits out one cycle even if it still reports idle.
  assign eligible   = engine_idle & ~engine_full & ~grant;
  assign rotated    = {eligible, eligible} >> ptr;
  assign last_x     = (scan_x == DATA_WIDTH'(X_PIXELS - 1));
  assign last_pixel = last_x && (scan_y == DATA_WIDTH'(Y_PIXELS - 1));

  always_comb begin
    found = 1'b0;
    sel   = '0;
    pos   = 0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (!found && rotated[i]) begin
        found = 1'b1;
        pos   = int'(ptr) + i;
        if (pos >= NUM_ENGINES) pos = pos - NUM_ENGINES;
        sel   = PW'(pos);
      end
    end
  end

  always_comb begin
    state_next  = state;
    ptr_next    = ptr;
    scan_x_next = scan_x;
    scan_y_next = scan_y;
    grant_next  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = DISPATCH;
          ptr_next    = '0;
          scan_x_next = '0;
          scan_y_next = '0;
        end
      end
      DISPATCH: begin
        if (found) begin
          grant_next = NUM_ENGINES'(1) << sel;
          ptr_next   = (sel == PW'(NUM_ENGINES - 1)) ? '0 : sel + 1'b1;
          if (last_pixel) begin
            state_next = DRAIN;
          end else if (last_x) begin
            scan_x_next = '0;
            scan_y_next = scan_y + 1'b1;
          end else begin
            scan_x_next = scan_x + 1'b1;
          end
        end
      end
      DRAIN: begin
        if ((grant == '0) && (&engine_idle)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr    <= '0;
      scan_x <= '0;
      scan_y <= '0;
      grant  <= '0;
      load   <= 1'b0;
      xpixel <= '0;
      ypixel <= '0;
    end else begin
      ptr    <= ptr_next;
      scan_x <= scan_x_next;
      scan_y <= scan_y_next;
      grant  <= grant_next;
      load   <= |grant_next;
      if (|grant_next) begin
        xpixel <= scan_x;
        ypixel <= scan_y;
      end
    end
  end

  assign busy       = (state == DISPATCH) || (state == DRAIN);
  assign frame_done = (state == DONE);

`ifdef DISPATCH_STALL_COUNT_EN
  logic stall;
  assign stall = (state == DISPATCH) && !found;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if ((state == IDLE) && start) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Randomised and directed bench for pixel_dispatcher against a cycle-level behavioural model.
module tb_pixel_dispatcher;

  localparam int NE   = 4;
  localparam int DW   = 10;
  localparam int XP   = 4;
  localparam int YP   = 2;
  localparam int NPIX = XP * YP;

  logic          clk;
  logic          reset;
  logic          start;
  logic [NE-1:0] engine_idle;
  logic [NE-1:0] engine_full;
  logic [NE-1:0] grant;
  logic          load;
  logic [DW-1:0] xpixel;
  logic [DW-1:0] ypixel;
  logic          busy;
  logic          frame_done;
`ifdef DISPATCH_STALL_COUNT_EN
  logic [31:0]   stall_count;
`endif

  pixel_dispatcher #(
    .NUM_ENGINES(NE),
    .DATA_WIDTH (DW),
    .X_PIXELS   (XP),
    .Y_PIXELS   (YP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .engine_idle(engine_idle),
    .engine_full(engine_full),
    .grant      (grant),
    .load       (load),
    .xpixel     (xpixel),
    .ypixel     (ypixel),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef DISPATCH_STALL_COUNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 dispatching, 2 draining, 3 done.
  int            m_phase;
  int            m_ptr;
  int            m_n;
  int            m_last;
  logic [NE-1:0] exp_grant;
  logic          exp_load;
  logic [DW-1:0] exp_x;
  logic [DW-1:0] exp_y;
  logic [31:0]   exp_stall;

  int frame_grants;
  int bad_coord;
  int done_cnt;
  int seen[NPIX];
  int order[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [NE-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NE; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_phase   = 0;
    m_ptr     = 0;
    m_n       = 0;
    m_last    = -1;
    exp_grant = '0;
    exp_load  = 1'b0;
    exp_x     = '0;
    exp_y     = '0;
    exp_stall = '0;
  endtask

  task automatic clear_book();
    frame_grants = 0;
    bad_coord    = 0;
    done_cnt     = 0;
    foreach (seen[i]) seen[i] = 0;
    order.delete();
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int k;
    k = -1;
    case (m_phase)
      0: if (start) begin
        m_phase   = 1;
        m_ptr     = 0;
        m_n       = 0;
        exp_stall = '0;
      end
      1: begin
        for (int j = 0; j < NE; j++) begin
          int e;
          e = (m_ptr + j) % NE;
          if (k < 0 && engine_idle[e] && !engine_full[e] && e != m_last) k = e;
        end
        if (k >= 0) begin
          exp_x = DW'(m_n % XP);
          exp_y = DW'(m_n / XP);
          m_n++;
          m_ptr = (k + 1) % NE;
          if (m_n == NPIX) m_phase = 2;
        end else if (exp_stall != 32'hffff_ffff) begin
          exp_stall = exp_stall + 32'd1;
        end
      end
      2: if (m_last < 0 && engine_idle == '1) m_phase = 3;
      default: m_phase = 0;
    endcase
    m_last    = k;
    exp_grant = '0;
    if (k >= 0) exp_grant[k] = 1'b1;
    exp_load = (k >= 0);
  endtask

  task automatic observe();
    chk("grant", 32'(grant), 32'(exp_grant));
    chk("load", 32'(load), 32'(exp_load));
    chk("xpixel", 32'(xpixel), 32'(exp_x));
    chk("ypixel", 32'(ypixel), 32'(exp_y));
    chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
    chk("frame_done", 32'(frame_done), 32'(m_phase == 3));
`ifdef DISPATCH_STALL_COUNT_EN
    chk("stall_count", stall_count, exp_stall);
`endif
    if (load) begin
      frame_grants++;
      order.push_back(onehot_idx(grant));
      if (int'(xpixel) < XP && int'(ypixel) < YP) seen[int'(ypixel) * XP + int'(xpixel)]++;
      else bad_coord++;
    end
    if (frame_done) begin
      int bad;
      bad = bad_coord;
      done_cnt++;
      chk("frame_grants", 32'(frame_grants), 32'(NPIX));
      foreach (seen[i]) if (seen[i] != 1) bad++;
      chk("frame_coverage", 32'(bad), 32'd0);
      frame_grants = 0;
      bad_coord    = 0;
      foreach (seen[i]) seen[i] = 0;
    end
  endtask

  task automatic step(input logic [NE-1:0] idle, input logic [NE-1:0] full, input logic st);
    engine_idle = idle;
    engine_full = full;
    start       = st;
    model_step();
    @(negedge clk);
    observe();
  endtask

  // mode 0: all idle, fixed full; 1: fully random; 2: all idle with random start
  task automatic finish_frame(input int mode, input logic [NE-1:0] full);
    int budget;
    logic [NE-1:0] id;
    logic [NE-1:0] fl;
    logic st;
    budget = 600;
    while (m_phase != 0 && budget > 0) begin
      id = '1;
      fl = full;
      st = 1'b0;
      if (mode == 1) begin
        id = NE'($urandom | $urandom);
        fl = NE'($urandom & $urandom & $urandom);
      end
      if (mode >= 1) st = 1'($urandom_range(0, 1));
      step(id, fl, st);
      budget--;
    end
    chk("frame_in_budget", 32'(budget > 0), 32'd1);
  endtask

  initial begin
    int p2[3];
    int budget;
    p2 = '{0, 2, 3};
    reset       = 1'b0;
    start       = 1'b0;
    engine_idle = '0;
    engine_full = '0;
    model_reset();
    clear_book();
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_x", 32'(xpixel), 32'd0);
    chk("rst_y", 32'(ypixel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
`ifdef DISPATCH_STALL_COUNT_EN
    chk("rst_stall", stall_count, 32'd0);
`endif
    reset = 1'b1;

    // Everyone idle: strict 0,1,2,3 rotation and raster order.
    clear_book();
    step('1, '0, 1'b1);
    finish_frame(0, '0);
    chk("s1_grants", 32'(order.size()), 32'(NPIX));
    for (int i = 0; i < order.size(); i++) chk("s1_order", 32'(order[i]), 32'(i % 4));
    chk("s1_done_cnt", 32'(done_cnt), 32'd1);

    // Engine 1 always full: it is skipped.
    clear_book();
    step('1, 4'b0010, 1'b1);
    finish_frame(0, 4'b0010);
    chk("s2_grants", 32'(order.size()), 32'(NPIX));
    for (int i = 0; i < order.size(); i++) chk("s2_order", 32'(order[i]), 32'(p2[i % 3]));

    // Five stall cycles in the middle of a frame.
    clear_book();
    step('1, '0, 1'b1);
    step('1, '0, 1'b0);
    step('1, '0, 1'b0);
    repeat (5) step('0, '0, 1'b0);
    chk("stall_load", 32'(load), 32'd0);
    chk("stall_hold_x", 32'(xpixel), 32'd1);
    chk("stall_hold_y", 32'(ypixel), 32'd0);
`ifdef DISPATCH_STALL_COUNT_EN
    chk("stall_five", stall_count, 32'd5);
`endif
    finish_frame(0, '0);

    // Engine 2 stays busy after the last pixel: dispatcher waits in drain.
    clear_book();
    step('1, '0, 1'b1);
    budget = 100;
    while (m_phase != 2 && budget > 0) begin
      step('1, '0, 1'b0);
      budget--;
    end
    chk("s4_reach_drain", 32'(budget > 0), 32'd1);
    repeat (10) step(4'b1011, '0, 1'b0);
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_no_done", 32'(frame_done), 32'd0);
    step('1, '0, 1'b0);
    chk("drain_done", 32'(frame_done), 32'd1);
    step('1, '0, 1'b0);
    chk("done_one_cycle", 32'(frame_done), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);

    // Asynchronous reset just after pixel (2,1) is dispatched.
    clear_book();
    step('1, '0, 1'b1);
    budget = 100;
    while (m_n < 7 && budget > 0) begin
      step('1, '0, 1'b0);
      budget--;
    end
    chk("pre_rst_x", 32'(xpixel), 32'd2);
    chk("pre_rst_y", 32'(ypixel), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_load", 32'(load), 32'd0);
    chk("mid_rst_x", 32'(xpixel), 32'd0);
    chk("mid_rst_y", 32'(ypixel), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(frame_done), 32'd0);
    model_reset();
    clear_book();
    @(negedge clk);
    reset = 1'b1;
    step('1, '0, 1'b1);
    finish_frame(0, '0);
    chk("restart_grants", 32'(order.size()), 32'(NPIX));
    if (order.size() > 0) chk("restart_first_engine", 32'(order[0]), 32'd0);

    // start held/toggled during the frame is ignored.
    clear_book();
    step('1, '0, 1'b1);
    finish_frame(2, '0);
    chk("s6_grants", 32'(order.size()), 32'(NPIX));
    chk("s6_done_cnt", 32'(done_cnt), 32'd1);

    // Random engine behaviour.
    for (int f = 0; f < 15; f++) begin
      clear_book();
      step(NE'($urandom), '0, 1'b1);
      finish_frame(1, '0);
      chk("rand_done_cnt", 32'(done_cnt), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
